// File: rtl/gray_pkg.sv
// Shared gray-code helpers for the gray decoder path.
// Functions run at a fixed wide width; callers zero-extend their operand and truncate the result.
package gray_pkg;

   localparam int MAXW = 64;

   // MSB-first prefix XOR. Zero upper bits leave the low bits unchanged.
   function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
      logic [MAXW-1:0] b;
      b[MAXW-1] = g[MAXW-1];
      for (int i = MAXW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic popcount_gt1(input logic [MAXW-1:0] x);
      return |(x & (x - MAXW'(1)));
   endfunction

endpackage

// File: rtl/gray_pipe_reg.sv
// One valid/ready register slice. It loads when it is empty or when its contents leave in this cycle.
module gray_pipe_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   assign in_ready  = !valid_q | out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
         valid_d = in_valid;
      end
      if (in_valid && in_ready) begin
         data_d = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/dec_gray2bin_pipe.sv
// Two-stage gray-to-binary decoder with a step monitor. S1 holds the raw gray value.
// S2 holds bin, delta and step_err, which are computed as a sample moves from S1 to S2.
module dec_gray2bin_pipe
   import gray_pkg::*;
#(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] gray,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] bin,
   output logic [W-1:0] delta,
   output logic         step_err,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         err_sticky
);

   localparam int S2W = 2*W + 1;

   logic           s1_valid;
   logic [W-1:0]   s1_gray;
   logic           s2_in_ready;
   logic [S2W-1:0] s2_data;

   logic [W-1:0]   bin_d, delta_d;
   logic           step_err_d;
   logic           s2_load;

   logic [W-1:0]   prev_gray_q, prev_bin_q;
   logic           have_prev_q;
   logic           err_sticky_q;

   gray_pipe_reg #(.DW(W)) u_s1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (gray),
      .in_ready  (in_ready),
      .out_valid (s1_valid),
      .out_data  (s1_gray),
      .out_ready (s2_in_ready)
   );

   assign s2_load = s1_valid & s2_in_ready;

   // The first sample after reset has no predecessor, so it reports a zero step.
   always_comb begin
      bin_d      = W'(gray2bin(MAXW'(s1_gray)));
      step_err_d = have_prev_q & popcount_gt1(MAXW'(s1_gray ^ prev_gray_q));
      delta_d    = have_prev_q ? (bin_d - prev_bin_q) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_gray_q <= '0;
         prev_bin_q  <= '0;
         have_prev_q <= 1'b0;
      end else if (s2_load) begin
         prev_gray_q <= s1_gray;
         prev_bin_q  <= bin_d;
         have_prev_q <= 1'b1;
      end
   end

   gray_pipe_reg #(.DW(S2W)) u_s2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_valid),
      .in_data   ({bin_d, delta_d, step_err_d}),
      .in_ready  (s2_in_ready),
      .out_valid (out_valid),
      .out_data  (s2_data),
      .out_ready (out_ready)
   );

   assign bin      = s2_data[S2W-1 -: W];
   assign delta    = s2_data[W:1];
   assign step_err = s2_data[0];

   // Only a step error that the consumer actually takes latches the sticky flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky_q <= 1'b0;
      end else if (out_valid && out_ready && step_err) begin
         err_sticky_q <= 1'b1;
      end
   end

   assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_dec_gray2bin_pipe.sv
// Randomized and directed checks of dec_gray2bin_pipe against an arithmetic reference model.
module tb_dec_gray2bin_pipe;

   localparam int W = 10;

   typedef struct packed {
      logic [W-1:0] bin;
      logic [W-1:0] delta;
      logic         serr;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] gray = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready, out_valid, step_err, err_sticky;
   logic [W-1:0] bin, delta;

   always #5 clk = ~clk;

   dec_gray2bin_pipe #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray       (gray),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .bin        (bin),
      .delta      (delta),
      .step_err   (step_err),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .err_sticky (err_sticky)
   );

   int checks = 0;
   int errors = 0;

   exp_t         exp_q[$];
   logic [W-1:0] drv_q[$];
   logic [W-1:0] m_prev_gray, m_prev_bin;
   bit           m_have_prev = 0;
   bit           m_sticky = 0;
   bit           held = 0;
   logic [W-1:0] held_bin, held_delta;
   logic         held_serr;
   logic [W-1:0] last_bin, last_delta;
   logic         last_serr;
   bit           acc;
   int           n_out = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Binary value of a gray code: XOR of all right shifts of the code.
   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = g;
      for (int s = 1; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // One clock: sample at negedge, score transfers, then step to 1ns after the next posedge.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      acc = 0;
      if (rst_n) begin
         chk("sticky", 32'(err_sticky), 32'(m_sticky));
         chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2 || out_ready));
         if (exp_q.size() == 0) chk("idle_valid", 32'(out_valid), 32'(0));
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_bin", 32'(bin), 32'(held_bin));
            chk("hold_delta", 32'(delta), 32'(held_delta));
            chk("hold_serr", 32'(step_err), 32'(held_serr));
         end
         held = out_valid && !out_ready;
         held_bin = bin; held_delta = delta; held_serr = step_err;
         if (out_valid && out_ready) begin
            last_bin = bin; last_delta = delta; last_serr = step_err;
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'(out_valid), 32'(0));
            end else begin
               e = exp_q.pop_front();
               n_out++;
               chk("bin", 32'(bin), 32'(e.bin));
               chk("delta", 32'(delta), 32'(e.delta));
               chk("step_err", 32'(step_err), 32'(e.serr));
               if (e.serr) m_sticky = 1;
            end
         end
         if (in_valid && in_ready) begin
            acc = 1;
            e.bin   = g2b(gray);
            e.serr  = m_have_prev && ($countones(gray ^ m_prev_gray) > 1);
            e.delta = m_have_prev ? W'(int'(e.bin) - int'(m_prev_bin)) : '0;
            m_prev_gray = gray;
            m_prev_bin  = e.bin;
            m_have_prev = 1;
            exp_q.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input int stall_at, input int stall_len, input bit rnd);
      int n;
      n = 0;
      while (drv_q.size() > 0 && n < 8000) begin
         gray     = drv_q[0];
         in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (n >= stall_at && n < stall_at + stall_len) out_ready = 1'b0;
         else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         cycle();
         if (acc) void'(drv_q.pop_front());
         n++;
      end
      in_valid = 1'b0;
      chk("feed_timeout", 32'(drv_q.size()), 32'(0));
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && n < 20) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic do_reset(input int ncyc);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      exp_q.delete();
      m_have_prev = 0;
      m_sticky    = 0;
      held        = 0;
      rst_n       = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_sticky", 32'(err_sticky), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] cb;
      int           n0;

      do_reset(3);

      // Single sample and latency
      out_ready = 1'b1;
      drv_q.push_back(10'h007);
      run(0, 0, 0);
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
      n0 = n_out;
      cycle();
      chk("lat_out", 32'(n_out), 32'(n0 + 1));
      chk("single_bin", 32'(last_bin), 32'(10'h005));
      chk("single_delta", 32'(last_delta), 32'(0));
      chk("single_serr", 32'(last_serr), 32'(0));

      // Full-range stream, including the wrap back to zero
      do_reset(3);
      for (int i = 0; i < 1024; i++) drv_q.push_back(b2g(W'(i)));
      drv_q.push_back(b2g(W'(0)));
      run(0, 0, 0);
      drain();
      chk("wrap_bin", 32'(last_bin), 32'(0));
      chk("wrap_delta", 32'(last_delta), 32'(1));
      chk("stream_sticky", 32'(err_sticky), 32'(0));

      // Three-bit step
      drv_q.push_back(10'h001);
      drv_q.push_back(10'h006);
      run(0, 0, 0);
      drain();
      chk("illegal_serr", 32'(last_serr), 32'(1));
      chk("illegal_bin", 32'(last_bin), 32'(10'h004));
      chk("illegal_delta", 32'(last_delta), 32'(10'h003));
      @(negedge clk);
      chk("illegal_sticky", 32'(err_sticky), 32'(1));
      @(posedge clk); #1;

      // Backpressure while streaming, including a backwards step
      for (int i = 4; i < 16; i++) drv_q.push_back(b2g(W'(i)));
      drv_q.push_back(b2g(W'(14)));
      run(3, 5, 0);
      drain();
      chk("bp_back_delta", 32'(last_delta), 32'(10'h3FF));

      // Reset with both stages full
      drv_q.push_back(10'h010);
      drv_q.push_back(10'h030);
      run(0, 10, 0);
      @(negedge clk);
      chk("full_valid", 32'(out_valid), 32'(1));
      chk("full_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("flush_valid", 32'(out_valid), 32'(0));
      do_reset(1);
      drv_q.push_back(10'h3FF);
      run(0, 0, 0);
      drain();
      chk("first_bin", 32'(last_bin), 32'(10'h2AA));
      chk("first_delta", 32'(last_delta), 32'(0));
      chk("first_serr", 32'(last_serr), 32'(0));

      // Random steps with random handshakes
      cb = W'($urandom);
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 7))
            0: ;
            1, 2, 3: cb = cb + 1'b1;
            4, 5: cb = cb - 1'b1;
            default: cb = W'($urandom);
         endcase
         drv_q.push_back(b2g(cb));
      end
      run(0, 0, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
